// File: rtl/w1_load_ctrl.sv
// Layer-1 weight load controller.
// Walks the conv-layer-1 weight ROM from index 0 to KNUM-1 once per start request.
// Each returned word is qualified for the consumer one cycle after its address goes out.
// Optional feature macro W1_STALL_EN adds a stall input for consumer back-pressure.
// With that macro defined, stall freezes the walk and replays the pending word.
// The parameters must satisfy 2**AW >= KNUM and KNUM >= 1.
module w1_load_ctrl #(
  parameter int unsigned KNUM = 25,
  parameter int unsigned AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef W1_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w1_raddr,
  output logic          w1_wr_en,
  output logic [AW-1:0] w1_wr_idx,
  output logic          w1_wr_last
);

  localparam logic [AW-1:0] LastIdx = AW'(KNUM - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_en_q, wr_en_d;
  logic          last_q, last_d;
  logic          hold;

`ifdef W1_STALL_EN
  assign hold = stall & busy;
`else
  assign hold = 1'b0;
`endif

  assign busy       = (state_q == StFetch) || (state_q == StDrain);
  assign done       = (state_q == StDone);
  // While held, re-issue the pending index so the ROM keeps the unconsumed word on its output.
  assign w1_raddr   = hold ? idx_q : addr_q;
  assign w1_wr_en   = wr_en_q & ~hold;
  assign w1_wr_last = last_q & ~hold;
  assign w1_wr_idx  = idx_q;

  // Next-state: advance the walk one address per cycle unless held by stall.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wr_en_d = 1'b0;
    last_d  = 1'b0;
    if (hold) begin
      wr_en_d = wr_en_q;
      last_d  = last_q;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StFetch;
            addr_d  = '0;
          end
        end
        StFetch: begin
          // The address issued last cycle comes back from the ROM this cycle.
          wr_en_d = 1'b1;
          idx_d   = addr_q;
          last_d  = (addr_q == LastIdx);
          if (addr_q == LastIdx) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        StDrain: state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_w1_load_ctrl.sv
// Self-checking bench for w1_load_ctrl: directed vector table, stall sequence (W1_STALL_EN),
// then random stimulus against a position-based reference model and a model ROM.
// Edge n is the n-th rising clock edge; inputs change 1 time unit after an edge.
module tb_w1_load_ctrl;
  localparam int KNUM = 25;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          stall_eff;
  logic          busy, done, w1_wr_en, w1_wr_last;
  logic [AW-1:0] w1_raddr, w1_wr_idx;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  w1_load_ctrl #(.KNUM(KNUM), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef W1_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .w1_raddr  (w1_raddr),
    .w1_wr_en  (w1_wr_en),
    .w1_wr_idx (w1_wr_idx),
    .w1_wr_last(w1_wr_last)
  );

`ifdef W1_STALL_EN
  assign stall_eff = stall;
`else
  assign stall_eff = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Model ROM with a 1-cycle registered read.
  logic [47:0] rom [2**AW];
  logic [47:0] rom_q;
  initial for (int i = 0; i < 2**AW; i++) rom[i] = 48'({$urandom(), $urandom()});
  always @(posedge clk) rom_q <= rom[w1_raddr];

  // Reference model: m_p counts productive cycles since the load was accepted.
  // p=0 first FETCH cycle, word p-1 delivered for p=1..KNUM, p=KNUM+1 done, then idle.
  bit m_active = 0;
  int m_p = 0;
  int m_raddr = 0;
  int m_idx = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 0; m_p <= 0; m_raddr <= 0; m_idx <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1; m_p <= 0; m_raddr <= 0;
      end
    end else if (!(m_p <= KNUM && stall_eff)) begin
      m_p <= m_p + 1;
      if (m_p + 1 <= KNUM - 1) m_raddr <= m_p + 1;
      if (m_p + 1 <= KNUM) m_idx <= m_p;
      if (m_p + 1 == KNUM + 2) m_active <= 0;
    end
  end

  // Mid-cycle comparison of every output against the model, plus lane and pulse scoreboard.
  int pulses = 0;
  always @(negedge clk) begin
    logic e_busy, e_done, e_en, e_last, st;
    int e_raddr;
    logic [47:0] cap;
    if (chk_en) begin
      e_busy  = m_active && m_p <= KNUM;
      e_done  = m_active && m_p == KNUM + 1;
      st      = e_busy && stall_eff;
      e_en    = e_busy && m_p >= 1 && !st;
      e_last  = e_en && m_p == KNUM;
      e_raddr = st ? m_idx : m_raddr;
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("wr_en", 64'(w1_wr_en), 64'(e_en));
      chk("wr_last", 64'(w1_wr_last), 64'(e_last));
      chk("wr_idx", 64'(w1_wr_idx), 64'(m_idx));
      chk("raddr", 64'(w1_raddr), 64'(e_raddr));
      if (w1_wr_en) begin
        for (int l = 0; l < 6; l++) cap[8*l +: 8] = rom_q[8*l +: 8];
        chk("rom_lanes", 64'(cap), 64'(rom[m_idx]));
      end
      if (rst) pulses = 0;
      else begin
        if (w1_wr_en) pulses++;
        if (done) begin
          chk("pulses_per_load", 64'(pulses), 64'(KNUM));
          pulses = 0;
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    chk_en = 1;
  end

  typedef struct {
    logic rst, start;
    int   reps;
    logic busy, done, en, last;
    int   idx, raddr;
  } vec_t;

  vec_t tbl [23];

  task automatic step(input logic r, input logic s, input logic st);
    rst = r; start = s; stall = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Basic load, ignored starts, back-to-back loads, reset mid-load, post-reset load.
    tbl[0]  = '{1, 0, 2,  0, 0, 0, 0, 0,  0};   // edges 1-2 reset
    tbl[1]  = '{0, 0, 7,  0, 0, 0, 0, 0,  0};   // edges 3-9 idle
    tbl[2]  = '{0, 1, 1,  1, 0, 0, 0, 0,  0};   // edge 10 start accepted
    tbl[3]  = '{0, 0, 1,  1, 0, 1, 0, 0,  1};   // edge 11 word 0
    tbl[4]  = '{0, 1, 1,  1, 0, 1, 0, 1,  2};   // edge 12 start ignored
    tbl[5]  = '{0, 0, 22, 1, 0, 1, 0, 23, 24};  // edge 34
    tbl[6]  = '{0, 0, 1,  1, 0, 1, 1, 24, 24};  // edge 35 last word, drain
    tbl[7]  = '{0, 1, 1,  0, 1, 0, 0, 24, 24};  // edge 36 done, start ignored
    tbl[8]  = '{0, 0, 1,  0, 0, 0, 0, 24, 24};  // edge 37 idle
    tbl[9]  = '{0, 0, 3,  0, 0, 0, 0, 24, 24};  // edges 38-40 not queued
    tbl[10] = '{0, 1, 1,  1, 0, 0, 0, 24, 0};   // edge 41 start held from here
    tbl[11] = '{0, 1, 26, 0, 1, 0, 0, 24, 24};  // edge 67 done
    tbl[12] = '{0, 1, 1,  0, 0, 0, 0, 24, 24};  // edge 68 one idle gap
    tbl[13] = '{0, 1, 1,  1, 0, 0, 0, 24, 0};   // edge 69 second load
    tbl[14] = '{0, 0, 26, 0, 1, 0, 0, 24, 24};  // edge 95 second done
    tbl[15] = '{0, 0, 1,  0, 0, 0, 0, 24, 24};
    tbl[16] = '{0, 1, 1,  1, 0, 0, 0, 24, 0};   // edge 97 start
    tbl[17] = '{0, 0, 9,  1, 0, 1, 0, 8,  9};   // edge 106 mid-load
    tbl[18] = '{1, 0, 1,  0, 0, 0, 0, 0,  0};   // edge 107 reset aborts
    tbl[19] = '{0, 0, 30, 0, 0, 0, 0, 0,  0};   // no done after abort
    tbl[20] = '{0, 1, 1,  1, 0, 0, 0, 0,  0};
    tbl[21] = '{0, 0, 26, 0, 1, 0, 0, 24, 24};  // full load completes
    tbl[22] = '{0, 0, 1,  0, 0, 0, 0, 24, 24};

    for (int v = 0; v < 23; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) step(tbl[v].rst, tbl[v].start, 1'b0);
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(tbl[v].busy));
      chk($sformatf("vec%0d_done", v), 64'(done), 64'(tbl[v].done));
      chk($sformatf("vec%0d_wr_en", v), 64'(w1_wr_en), 64'(tbl[v].en));
      chk($sformatf("vec%0d_wr_last", v), 64'(w1_wr_last), 64'(tbl[v].last));
      chk($sformatf("vec%0d_wr_idx", v), 64'(w1_wr_idx), 64'(tbl[v].idx));
      chk($sformatf("vec%0d_raddr", v), 64'(w1_raddr), 64'(tbl[v].raddr));
    end

`ifdef W1_STALL_EN
    // Stall while word 4 is pending: raddr replays 4, word 4 reappears after release.
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1;
      chk("stall_raddr", 64'(w1_raddr), 64'd4);
      chk("stall_wr_en", 64'(w1_wr_en), 64'd0);
      chk("stall_idx", 64'(w1_wr_idx), 64'd4);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    #1;
    chk("unstall_wr_en", 64'(w1_wr_en), 64'd1);
    chk("unstall_idx", 64'(w1_wr_idx), 64'd4);
    repeat (21) step(0, 0, 0);
    chk("stall_done", 64'(done), 64'd1);
    repeat (2) step(0, 0, 0);
`endif

    // Random traffic; the model and scoreboard check every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic r, s, st;
      r  = ($urandom_range(0, 79) == 0);
      s  = ($urandom_range(0, 3) == 0) || (n % 400 > 300);
      st = 1'b0;
`ifdef W1_STALL_EN
      st = ($urandom_range(0, 3) == 0);
`endif
      step(r, s, st);
    end

    step(1, 0, 0);
    step(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
